n_bit_down_timer: RTL and testbench
===================================

# n_bit_down_timer

Loadable N-bit down-counter timer: the counting-down counterpart to the team's N-bit up-counter. It is loaded with a start value, decrements once per enabled cycle, and flags terminal count with a single-cycle `done_o` pulse. It supports one-shot and auto-reload (periodic) modes, and is used wherever a block must wait a programmed number of enabled cycles (timeouts, tick dividers, bit-period timers).

## Interface
- `CNT_BIT_WIDTH`, default 3: width of counter, load value and reload register.

- `clk`  in  1  rising-edge clock.
- `reset_i`  in  1  asynchronous, active-high reset.
- `load_i`  in  1  synchronous load/restart strobe; samples `load_val_i`.
- `load_val_i`  in  CNT_BIT_WIDTH  start/reload value (unsigned, 0 to 2^N-1).
- `enable_i`  in  1  count-enable; decrement only in cycles where high.
- `stop_i`  in  1  synchronous abort; returns to IDLE, holding the count.
- `auto_reload_i`  in  1  1 = periodic mode, 0 = one-shot; sampled at terminal count.
- `cout_o`  out  CNT_BIT_WIDTH  current count (registered).
- `zero_o`  out  1  registered; always equals (`cout_o` == 0).
- `done_o`  out  1  registered one-cycle pulse at terminal count.
- `busy_o`  out  1  high while in RUN.

## Operation
- Reset state: IDLE. `cout_o`=0, reload register=0, `zero_o`=1, `done_o`=0, `busy_o`=0. Reset acts immediately, mid-count included.
- Per-edge priority: reset > `load_i` > `stop_i` > decrement.
- Two-state FSM: IDLE, RUN. `busy_o` = (state == RUN).
- IDLE:
  - `load_i`=1: `cout_o` and the reload register take `load_val_i`.
    - If value != 0, go to RUN.
    - If value == 0, stay in IDLE with no `done_o`.
  - Otherwise `cout_o` holds and `enable_i` is ignored.
- RUN, `load_i`=1: restart. `cout_o` and the reload register take `load_val_i`. Stay in RUN if value != 0, else go to IDLE. No decrement that cycle, no `done_o`.
- RUN, `stop_i`=1 (and `load_i`=0): go to IDLE. `cout_o` holds its current value, no `done_o`.
- RUN, `enable_i`=0: hold (pause). State and `busy_o` are unchanged.
- RUN, `enable_i`=1, `cout_o` > 1: `cout_o` <= `cout_o` - 1.
- RUN, `enable_i`=1, `cout_o` == 1 (terminal count): `done_o` <= 1 for the next cycle.
  - If `auto_reload_i`=1: `cout_o` <= reload register, stay in RUN. The count never shows 0, so the period is exactly the reload value in enabled cycles.
  - If `auto_reload_i`=0: `cout_o` <= 0, go to IDLE.
- `done_o` is 0 in every cycle other than the one after a terminal-count edge.
- Arithmetic is unsigned CNT_BIT_WIDTH. Decrement never wraps below 0, because 0 is never decremented. A full-scale load (all ones) times 2^N-1 enabled cycles.
- `zero_o` is registered from the next-state count and is consistent with `cout_o` in every cycle.

## Timing
- Load latency: `load_i` sampled at edge k gives `cout_o`=V and `busy_o`=1 after edge k.
- With `enable_i` held high from edge k+1: `cout_o`=V-j after edge k+j, for j < V.
- Terminal count at edge k+V:
  - One-shot: `cout_o`=0, `zero_o`=1, `busy_o`=0, `done_o`=1 for exactly one cycle.
  - Auto-reload: `cout_o`=V, `done_o`=1. The next pulse follows V enabled cycles later.
- Paused cycles (`enable_i`=0) stretch the timeline one cycle each. Pulse width is unaffected.
- `load_i` on the terminal-count edge: the load wins and `done_o` stays 0.
- `stop_i` on the terminal-count edge: the stop wins, `cout_o` stays 1 and `done_o` stays 0.
- `auto_reload_i` matters only on the terminal-count edge. It may change freely at other times.

## Test plan
- Reset/one-shot (N=3): assert `reset_i` and check outputs 0/1/0/0. Load 5, then `enable_i`=1 -> `cout_o` 5,4,3,2,1,0; `done_o` high only in the cycle `cout_o`=0; then `busy_o`=0 and `zero_o`=1.
- Auto-reload: load 3 with `auto_reload_i`=1 and `enable_i`=1 -> `cout_o` 3,2,1,3,2,1,3; `done_o` pulses every 3rd cycle and `zero_o` never asserts.
- Pause/stop: load 6 and enable 2 cycles (`cout_o`=4). Drop `enable_i` 3 cycles -> `cout_o` holds 4, `busy_o`=1. Then `stop_i` -> IDLE, `cout_o`=4; `enable_i` alone does not move it.
- Collisions: at `cout_o`=1, apply `load_i`=1 with `load_val_i`=7 -> `cout_o`=7, no `done_o`. Repeat with `stop_i` -> `cout_o`=1, `done_o`=0. Load 0 -> stays IDLE, no pulse.
- Full scale/async reset: load 7 and enable 7 cycles -> single `done_o`. Reload 7, then pulse `reset_i` between clock edges mid-count -> outputs reset immediately, before the next edge.

Source files
------------

// File: rtl/n_bit_down_timer.sv
// n_bit_down_timer: loadable N-bit down-counter with one-shot / auto-reload modes.
//   Loaded with a start value, decrements once per enabled cycle while running,
//   and pulses done_o for one cycle at terminal count.
// Ports:
//   clk            rising-edge clock
//   reset_i        asynchronous active-high reset
//   load_i         synchronous load/restart strobe (samples load_val_i)
//   load_val_i     start/reload value
//   enable_i       count enable
//   stop_i         synchronous abort to IDLE, count held
//   auto_reload_i  1 = periodic, 0 = one-shot (sampled at terminal count)
//   cout_o         current count
//   zero_o         cout_o == 0
//   done_o         one-cycle terminal-count pulse
//   busy_o         high while running
module n_bit_down_timer #(
  parameter int unsigned CNT_BIT_WIDTH = 3
) (
  input  logic                     clk,
  input  logic                     reset_i,
  input  logic                     load_i,
  input  logic [CNT_BIT_WIDTH-1:0] load_val_i,
  input  logic                     enable_i,
  input  logic                     stop_i,
  input  logic                     auto_reload_i,
  output logic [CNT_BIT_WIDTH-1:0] cout_o,
  output logic                     zero_o,
  output logic                     done_o,
  output logic                     busy_o
);

  localparam int unsigned W = CNT_BIT_WIDTH;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [W-1:0]   r_cnt;
  logic [W-1:0]   r_reload;
  logic [W-1:0]   w_cnt_nxt;
  logic [W-1:0]   w_reload_nxt;
  logic           r_zero;
  logic           r_done;
  logic           r_busy;
  logic           w_done_nxt;
  logic           w_terminal;

  // Terminal-count edge: only reached when neither load nor stop takes priority.
  assign w_terminal = (r_state == RUN) && !load_i && !stop_i && enable_i &&
                      (r_cnt == W'(1));

  // State register
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (load_i && (load_val_i != '0)) begin
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        if (load_i) begin
          if (load_val_i == '0) begin
            w_state_nxt = IDLE;
          end
        end else if (stop_i) begin
          w_state_nxt = IDLE;
        end else if (w_terminal && !auto_reload_i) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    w_cnt_nxt    = r_cnt;
    w_reload_nxt = r_reload;
    w_done_nxt   = 1'b0;
    if (load_i) begin
      w_cnt_nxt    = load_val_i;
      w_reload_nxt = load_val_i;
    end else if ((r_state == RUN) && !stop_i && enable_i) begin
      if (r_cnt == W'(1)) begin
        // Reload skips the zero count so the period equals the reload value.
        w_done_nxt = 1'b1;
        w_cnt_nxt  = auto_reload_i ? r_reload : '0;
      end else if (r_cnt != '0) begin
        w_cnt_nxt = r_cnt - W'(1);
      end
    end
  end

  // Registered outputs
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      r_cnt    <= '0;
      r_reload <= '0;
      r_zero   <= 1'b1;
      r_done   <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_cnt    <= w_cnt_nxt;
      r_reload <= w_reload_nxt;
      r_zero   <= (w_cnt_nxt == '0);
      r_done   <= w_done_nxt;
      r_busy   <= (w_state_nxt == RUN);
    end
  end

  assign cout_o = r_cnt;
  assign zero_o = r_zero;
  assign done_o = r_done;
  assign busy_o = r_busy;

endmodule

// File: tb/tb_n_bit_down_timer.sv
// Scoreboard bench for n_bit_down_timer (N=3): stimulus pushes expected
// post-edge outputs from a behavioural model; a monitor pops and compares.
module tb_n_bit_down_timer;

  localparam int unsigned W = 3;

  logic         clk;
  logic         reset_i;
  logic         load_i;
  logic [W-1:0] load_val_i;
  logic         enable_i;
  logic         stop_i;
  logic         auto_reload_i;
  logic [W-1:0] cout_o;
  logic         zero_o;
  logic         done_o;
  logic         busy_o;

  typedef struct {
    int cout;
    int zero;
    int done;
    int busy;
  } exp_t;

  exp_t q[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  // Behavioural model state
  int  m_cnt    = 0;
  int  m_reload = 0;
  bit  m_run    = 0;
  bit  m_done   = 0;

  n_bit_down_timer #(.CNT_BIT_WIDTH(W)) dut (
    .clk          (clk),
    .reset_i      (reset_i),
    .load_i       (load_i),
    .load_val_i   (load_val_i),
    .enable_i     (enable_i),
    .stop_i       (stop_i),
    .auto_reload_i(auto_reload_i),
    .cout_o       (cout_o),
    .zero_o       (zero_o),
    .done_o       (done_o),
    .busy_o       (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, req);
    end
  endtask

  task automatic check_all(input exp_t e);
    check("cout", int'(cout_o), e.cout);
    check("zero", int'(zero_o), e.zero);
    check("done", int'(done_o), e.done);
    check("busy", int'(busy_o), e.busy);
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e.cout = m_cnt;
    e.zero = (m_cnt == 0) ? 1 : 0;
    e.done = m_done ? 1 : 0;
    e.busy = m_run ? 1 : 0;
    return e;
  endfunction

  function automatic void model_reset();
    m_cnt = 0; m_reload = 0; m_run = 0; m_done = 0;
  endfunction

  // Apply one cycle of stimulus at the falling edge and predict the result.
  task automatic cyc(input bit ld, input int val, input bit en, input bit st, input bit ar);
    @(negedge clk);
    load_i        = ld;
    load_val_i    = W'(val);
    enable_i      = en;
    stop_i        = st;
    auto_reload_i = ar;
    m_done = 0;
    if (ld) begin
      m_cnt = val; m_reload = val; m_run = (val != 0);
    end else if (m_run && st) begin
      m_run = 0;
    end else if (m_run && en) begin
      if (m_cnt == 1) begin
        m_done = 1;
        if (ar) m_cnt = m_reload;
        else begin m_cnt = 0; m_run = 0; end
      end else begin
        m_cnt = m_cnt - 1;
      end
    end
    q.push_back(model_out());
  endtask

  // Monitor: compare each edge's outputs against the oldest prediction.
  always @(posedge clk) begin
    #1;
    if (!reset_i && q.size() > 0) begin
      check_all(q.pop_front());
    end
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  exp_t rst_e;

  initial begin
    rst_e.cout = 0; rst_e.zero = 1; rst_e.done = 0; rst_e.busy = 0;
    reset_i = 1'b1; load_i = 0; load_val_i = '0; enable_i = 0; stop_i = 0; auto_reload_i = 0;
    #1;
    check_all(rst_e);
    repeat (2) @(negedge clk);
    reset_i = 1'b0;
    model_reset();

    // One-shot from 5
    cyc(1, 5, 0, 0, 0);
    repeat (7) cyc(0, 0, 1, 0, 0);

    // Auto-reload period 3
    cyc(1, 3, 1, 0, 1);
    repeat (9) cyc(0, 0, 1, 0, 1);

    // Pause then stop
    cyc(1, 6, 0, 0, 0);
    repeat (2) cyc(0, 0, 1, 0, 0);
    repeat (3) cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 1, 1, 0);
    repeat (3) cyc(0, 0, 1, 0, 0);

    // Load collides with terminal count
    cyc(1, 2, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);
    cyc(1, 7, 1, 0, 0);
    cyc(0, 0, 1, 0, 0);
    // Stop collides with terminal count
    cyc(1, 1, 0, 0, 0);
    cyc(0, 0, 1, 1, 1);
    cyc(0, 0, 1, 0, 0);
    // Load zero stays idle
    cyc(1, 0, 1, 0, 0);
    repeat (2) cyc(0, 0, 1, 0, 0);

    // Full scale one-shot
    cyc(1, 7, 0, 0, 0);
    repeat (9) cyc(0, 0, 1, 0, 0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 9) == 0), int'($urandom_range(0, 7)),
          ($urandom_range(0, 9) < 7), ($urandom_range(0, 19) == 0),
          $urandom_range(0, 1) == 1);
    end

    // Async reset between edges, mid-count
    cyc(1, 7, 0, 0, 0);
    repeat (2) cyc(0, 0, 1, 0, 0);
    @(posedge clk);
    #3;
    reset_i = 1'b1;
    #1;
    check_all(rst_e);
    model_reset();
    q.delete();
    @(negedge clk);
    reset_i = 1'b0;
    cyc(1, 4, 1, 0, 1);
    repeat (6) cyc(0, 0, 1, 0, 1);

    repeat (2) @(negedge clk);
    check("queue_drained", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
